// File: rtl/mem_handle_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_handle_responder_if
// Description : Requester handshake plus backing-memory bus for the responder.
// Revision    : 1.0
// ============================================================================
interface mem_handle_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              avail;
  logic              r_en;
  logic              w_en;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] data_store;
  logic              read_through;
  logic              write_through;
  logic              done;
  logic [DATA_W-1:0] data_load;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  avail, r_en, w_en, ptr, data_store, read_through, write_through,
    input  mem_ack, mem_rdata,
    output done, data_load, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output avail, r_en, w_en, ptr, data_store, read_through, write_through,
    output mem_ack, mem_rdata,
    input  done, data_load, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_handle_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_handle_responder
// Description : Handle read/write responder with a one-entry dirty write buffer.
// Revision    : 1.0
// ============================================================================
module mem_handle_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_l,
  mem_handle_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FLUSH  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PEND_CAPTURE = 2'd0,
    PEND_RD      = 2'd1,
    PEND_WR      = 2'd2
  } pend_t;

  state_t            r_state,     w_state_nxt;
  pend_t             r_pend,      w_pend_nxt;
  logic [ADDR_W-1:0] r_ptr,       w_ptr_nxt;
  logic [DATA_W-1:0] r_wdata,     w_wdata_nxt;
  logic              r_buf_valid, w_buf_valid_nxt;
  logic [ADDR_W-1:0] r_buf_addr,  w_buf_addr_nxt;
  logic [DATA_W-1:0] r_buf_data,  w_buf_data_nxt;
  logic [DATA_W-1:0] r_data_load, w_data_load_nxt;
  logic              r_ack_d,     w_ack_d_nxt;

  logic              w_go;
  logic              w_hit;
  logic              w_mem_req;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_done;
  logic              w_acked;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state     <= IDLE;
      r_pend      <= PEND_CAPTURE;
      r_ptr       <= '0;
      r_wdata     <= '0;
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_data_load <= '0;
      r_ack_d     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_ptr       <= w_ptr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_buf_addr  <= w_buf_addr_nxt;
      r_buf_data  <= w_buf_data_nxt;
      r_data_load <= w_data_load_nxt;
      r_ack_d     <= w_ack_d_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_nxt      = r_pend;
    w_ptr_nxt       = r_ptr;
    w_wdata_nxt     = r_wdata;
    w_buf_valid_nxt = r_buf_valid;
    w_buf_addr_nxt  = r_buf_addr;
    w_buf_data_nxt  = r_buf_data;
    w_data_load_nxt = r_data_load;
    w_mem_req       = 1'b0;
    w_mem_we        = 1'b0;
    w_mem_addr      = '0;
    w_mem_wdata     = '0;
    w_done          = 1'b0;
    w_go            = bus.avail & (bus.r_en | bus.w_en);
    w_hit           = r_buf_valid && (r_buf_addr == bus.ptr);

    // r_ack_d holds mem_req low for one cycle after every acknowledge, including
    // the hand-over from a flush straight into MEM_RD or MEM_WR.
    unique case (r_state)
      IDLE: begin
        if (w_go) begin
          w_ptr_nxt   = bus.ptr;
          w_wdata_nxt = bus.data_store;
          if (!bus.w_en) begin
            if (!bus.read_through && w_hit) begin
              w_data_load_nxt = r_buf_data;
              w_state_nxt     = RESP;
            end else if (bus.read_through && r_buf_valid) begin
              w_pend_nxt  = PEND_RD;
              w_state_nxt = FLUSH;
            end else begin
              w_state_nxt = MEM_RD;
            end
          end else if (!bus.write_through) begin
            if (!r_buf_valid || w_hit) begin
              w_buf_valid_nxt = 1'b1;
              w_buf_addr_nxt  = bus.ptr;
              w_buf_data_nxt  = bus.data_store;
              w_state_nxt     = RESP;
            end else begin
              w_pend_nxt  = PEND_CAPTURE;
              w_state_nxt = FLUSH;
            end
          end else begin
            if (r_buf_valid && !w_hit) begin
              w_pend_nxt  = PEND_WR;
              w_state_nxt = FLUSH;
            end else begin
              w_buf_valid_nxt = 1'b0;
              w_state_nxt     = MEM_WR;
            end
          end
        end
      end
      FLUSH: begin
        w_mem_req   = !r_ack_d;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_buf_addr;
        w_mem_wdata = r_buf_data;
        if (w_mem_req && bus.mem_ack) begin
          w_buf_valid_nxt = 1'b0;
          unique case (r_pend)
            PEND_CAPTURE: begin
              w_buf_valid_nxt = 1'b1;
              w_buf_addr_nxt  = r_ptr;
              w_buf_data_nxt  = r_wdata;
              w_state_nxt     = RESP;
            end
            PEND_RD: w_state_nxt = MEM_RD;
            default: w_state_nxt = MEM_WR;
          endcase
        end
      end
      MEM_RD: begin
        w_mem_req  = !r_ack_d;
        w_mem_addr = r_ptr;
        if (w_mem_req && bus.mem_ack) begin
          w_data_load_nxt = bus.mem_rdata;
          w_state_nxt     = RESP;
        end
      end
      MEM_WR: begin
        w_mem_req   = !r_ack_d;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_ptr;
        w_mem_wdata = r_wdata;
        if (w_mem_req && bus.mem_ack) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_acked     = w_mem_req & bus.mem_ack;
    w_ack_d_nxt = w_acked;
  end

  assign bus.done      = w_done;
  assign bus.data_load = r_data_load;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_handle_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_handle_responder
// Description : Scoreboard bench with a delayed-ack backing-memory model.
// Revision    : 1.0
// ============================================================================
module tb_mem_handle_responder;

  logic clk = 1'b0;
  logic rst_l;
  always #5 clk = ~clk;

  mem_handle_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_handle_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  done_t       done_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem [logic [31:0]];
  int          vectors     = 0;
  int          miscompares = 0;
  int          ack_dly     = 0;
  int          req_cnt     = 0;
  int          req_cycles  = 0;
  bit          bv          = 1'b0;
  logic [31:0] ba          = '0;
  logic [31:0] bd          = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic void push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wr_q.push_back(w);
  endfunction

  // Monitor and backing-memory responder, both on the falling edge.
  initial begin
    done_t e;
    wr_t   w;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) req_cycles++;
      if (bus.done) begin
        if (done_q.size() == 0) chk("spurious_done", 1, 0);
        else begin
          e = done_q.pop_front();
          if (e.is_rd) chk("data_load", bus.data_load, e.data);
        end
      end
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        req_cnt     = 0;
        chk("req_drop_after_ack", bus.mem_req, 0);
      end else if (bus.mem_req) begin
        req_cnt++;
        if (req_cnt > ack_dly) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            if (wr_q.size() == 0) chk("unexpected_mem_write", 1, 0);
            else begin
              w = wr_q.pop_front();
              chk("mem_waddr", bus.mem_addr, w.addr);
              chk("mem_wdata", bus.mem_wdata, w.data);
            end
            mem[bus.mem_addr] = bus.mem_wdata;
          end else begin
            bus.mem_rdata = memval(bus.mem_addr);
          end
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  task automatic issue(input bit rd, input bit wr, input logic [31:0] p, input logic [31:0] d,
                       input bit rt, input bit wt, input int exp_lat);
    done_t e;
    int    n;
    if (wr) begin
      e.is_rd = 1'b0;
      e.data  = '0;
      if (!wt) begin
        if (bv && ba != p) push_wr(ba, bd);
        bv = 1'b1; ba = p; bd = d;
      end else begin
        if (bv && ba != p) push_wr(ba, bd);
        push_wr(p, d);
        bv = 1'b0;
      end
    end else begin
      e.is_rd = 1'b1;
      if (!rt && bv && ba == p) e.data = bd;
      else if (rt && bv) begin
        push_wr(ba, bd);
        e.data = (ba == p) ? bd : memval(p);
        bv = 1'b0;
      end else e.data = memval(p);
    end
    done_q.push_back(e);

    @(negedge clk);
    bus.avail = 1'b1; bus.r_en = rd; bus.w_en = wr; bus.ptr = p; bus.data_store = d;
    bus.read_through = rt; bus.write_through = wt;
    @(posedge clk);
    #1;
    // Scramble request fields so a design that doesn't latch them gets caught.
    bus.avail = 1'b0; bus.r_en = 1'b0; bus.w_en = 1'b0;
    bus.ptr = ~p; bus.data_store = ~d; bus.read_through = ~rt; bus.write_through = ~wt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 200);
    chk("done_seen", bus.done, 1);
    if (exp_lat > 0) chk("latency", n, exp_lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int rc;
    rst_l = 1'b0;
    bus.avail = 1'b0; bus.r_en = 1'b0; bus.w_en = 1'b0; bus.ptr = '0; bus.data_store = '0;
    bus.read_through = 1'b0; bus.write_through = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done",      bus.done, 0);
    chk("rst_mem_req",   bus.mem_req, 0);
    chk("rst_mem_we",    bus.mem_we, 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_data_load", bus.data_load, 0);
    rst_l = 1'b1;

    // Buffered write then read hit: no memory traffic.
    rc = req_cycles;
    issue(0, 1, 32'h10, 32'h1, 0, 0, 1);
    issue(1, 0, 32'h10, 32'h0, 0, 0, 1);
    chk("hit_no_mem_req", req_cycles - rc, 0);

    // Write to a different address flushes the old entry first.
    issue(0, 1, 32'h11, 32'h2, 0, 0, 0);
    issue(1, 0, 32'h11, 32'h0, 0, 0, 1);

    // Write-through with slow memory: flush then write, buffer left empty.
    ack_dly = 3;
    issue(0, 1, 32'h20, 32'h3, 0, 1, 0);
    issue(1, 0, 32'h11, 32'h0, 0, 0, 0);
    ack_dly = 0;
    issue(0, 1, 32'h40, 32'h4, 0, 0, 1);

    // Read-through of the buffered address sees the flushed data.
    mem[32'h30] = 32'h9;
    issue(0, 1, 32'h30, 32'h5, 0, 0, 0);
    ack_dly = 1;
    issue(1, 0, 32'h30, 32'h0, 1, 0, 0);
    ack_dly = 0;

    // Plain read miss leaves the buffer alone.
    issue(0, 1, 32'h50, 32'h7, 0, 0, 1);
    issue(1, 0, 32'h60, 32'h0, 0, 0, 0);
    issue(1, 0, 32'h50, 32'h0, 0, 0, 1);

    // r_en and w_en together is a write; null request yields nothing.
    issue(1, 1, 32'h50, 32'h8, 0, 0, 1);
    issue(1, 0, 32'h50, 32'h0, 0, 0, 1);
    rc = req_cycles;
    @(negedge clk);
    bus.avail = 1'b1; bus.r_en = 1'b0; bus.w_en = 1'b0; bus.ptr = 32'h99;
    @(negedge clk);
    bus.avail = 1'b0;
    repeat (4) @(negedge clk);
    chk("null_no_mem_req", req_cycles - rc, 0);

    // Write-through to the buffered address invalidates it.
    issue(0, 1, 32'h50, 32'h9, 0, 1, 0);
    issue(1, 0, 32'h50, 32'h0, 0, 0, 0);

    // Reset while waiting in MEM_RD.
    issue(0, 1, 32'h70, 32'hB, 0, 0, 1);
    ack_dly = 10;
    @(negedge clk);
    bus.avail = 1'b1; bus.r_en = 1'b1; bus.w_en = 1'b0; bus.ptr = 32'h80;
    bus.read_through = 1'b0; bus.write_through = 1'b0;
    @(posedge clk);
    #1;
    bus.avail = 1'b0; bus.r_en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_req && n < 20);
    chk("rd_req_seen", bus.mem_req, 1);
    rst_l = 1'b0;
    @(negedge clk);
    chk("rst_mid_req",  bus.mem_req, 0);
    chk("rst_mid_done", bus.done, 0);
    chk("rst_mid_load", bus.data_load, 0);
    rst_l = 1'b1;
    bv = 1'b0;
    ack_dly = 0;
    rc = req_cycles;
    repeat (4) @(negedge clk);
    chk("post_rst_quiet", req_cycles - rc, 0);
    issue(1, 0, 32'h70, 32'h0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("done_q_empty", done_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_handle_responder.md
MEM_HANDLE_RESPONDER -- requirements
Module: mem_handle_responder

Interface
REQ-001 Parameter: ADDR_W, 32, width of the handle pointer and the backing-memory address.
REQ-002 Parameter: DATA_W, 32, width of the handle data and the backing-memory data.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_l  input  1  reset, synchronous, active-low.
REQ-005 Port: avail  input  1  requester has a valid request.
REQ-006 Port: r_en  input  1  request is a read.
REQ-007 Port: w_en  input  1  request is a write.
REQ-008 Port: ptr  input  ADDR_W  request address.
REQ-009 Port: data_store  input  DATA_W  write data.
REQ-010 Port: read_through  input  1  read bypasses the buffer and must reflect backing memory.
REQ-011 Port: write_through  input  1  write, and any buffered dirty data, must reach backing memory before done.
REQ-012 Port: done  output  1  one-cycle completion pulse to the requester.
REQ-013 Port: data_load  output  DATA_W  read data; valid while done=1.
REQ-014 Port: mem_req  output  1  backing-memory request; held until mem_ack.
REQ-015 Port: mem_we  output  1  backing-memory write strobe; qualified by mem_req.
REQ-016 Port: mem_addr / mem_wdata  output  ADDR_W / DATA_W  backing-memory address and write data.
REQ-017 Port: mem_ack  input  1  one-cycle acknowledge; mem_rdata is valid in the same cycle.
REQ-018 Port: mem_rdata  input  DATA_W  backing-memory read data.

Function
REQ-019 The block SHALL hold a one-entry write buffer: buf_valid, buf_addr, buf_data. Any valid entry is dirty.
REQ-020 FSM states SHALL be IDLE, FLUSH, MEM_RD, MEM_WR, RESP.
REQ-021 IDLE SHALL sample a request only when avail=1 and (r_en|w_en)=1. avail=1 with r_en=w_en=0 SHALL be ignored. r_en=w_en=1 SHALL be treated as a write.
REQ-022 Read, not read_through, buf_valid, buf_addr==ptr: go to RESP with data_load=buf_data. Done SHALL appear 1 cycle after the request is sampled.
REQ-023 Read in any other case: go to FLUSH if read_through and buf_valid; otherwise go to MEM_RD.
REQ-024 Write, not write_through: if buffer empty or buf_addr==ptr, capture ptr/data_store into the buffer and go to RESP (1-cycle latency). Otherwise go to FLUSH, then capture, then RESP.
REQ-025 Write with write_through: if buf_valid and buf_addr!=ptr, go to FLUSH, then MEM_WR. If buf_addr==ptr, invalidate the buffer and go to MEM_WR. Otherwise go to MEM_WR.
REQ-026 FLUSH SHALL drive mem_req=1, mem_we=1, mem_addr=buf_addr, mem_wdata=buf_data until mem_ack, then clear buf_valid and continue to the pending action.
REQ-027 MEM_RD SHALL drive mem_req=1, mem_we=0, mem_addr=latched ptr. On mem_ack it SHALL latch mem_rdata into data_load and go to RESP.
REQ-028 MEM_WR SHALL drive mem_req=1, mem_we=1 with the latched ptr/data until mem_ack, then go to RESP.
REQ-029 Request fields SHALL be latched at sampling. Later changes to ptr/data_store SHALL not affect the transaction in flight.
REQ-030 mem_req, mem_addr, mem_wdata and mem_we SHALL stay stable from assertion until the mem_ack cycle. mem_req SHALL be 0 in the cycle after mem_ack.
REQ-031 RESP SHALL assert done=1 for exactly one cycle, then return to IDLE. The request inputs SHALL not be sampled during the RESP cycle.
REQ-032 data_load SHALL hold its last value when done=0.
REQ-033 A read that misses the buffer and has no read_through SHALL read memory without flushing the buffer.

Reset
REQ-034 When rst_l=0 at a clock edge: state=IDLE, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, data_load=0, buf_valid=0, buf_addr=0, buf_data=0.
REQ-035 Reset mid-transaction SHALL abandon the transaction. Buffered dirty data SHALL be discarded, with no done pulse and no further mem_req.

Verification
REQ-036 Write A=0x10/0x1 (no write_through), then read A=0x10 -> done 1 cycle after each request, data_load=0x1, mem_req never asserted.
REQ-037 Buffer holds 0x10/0x1, then write 0x11/0x2 -> memory write 0x10/0x1 first, then done; buffer holds 0x11/0x2.
REQ-038 Buffer holds 0x11/0x2, then write_through write 0x20/0x3 with mem_ack delayed 3 cycles each -> memory writes 0x11/0x2 then 0x20/0x3, one done, buffer empty.
REQ-039 Buffer holds 0x30/0x5, memory[0x30]=0x9, read_through read 0x30 -> flush writes 0x5, memory read returns 0x5, data_load=0x5.
REQ-040 Back-to-back requests (avail low for 1 cycle between them) and avail with r_en=w_en=0 -> each real request gets exactly one done; the null request gets none.
REQ-041 rst_l=0 while in MEM_RD awaiting mem_ack -> mem_req=0 next cycle, no done, buffer invalid.
